// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared FSM state type and minimum legal divide ratio for clk_div_ctrl
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_e;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/clk_div_counter.sv
// clk_div_counter: period counter 0..div-1; ports clk_in/rst/load/div in, cnt/period_end/phase_hi (high phase of upcoming count) out
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] cnt,
  output logic             period_end,
  output logic             phase_hi
);
  logic [DIV_W-1:0] cnt_q, cnt_d, half;
  assign half       = (div >> 1) + {{(DIV_W-1){1'b0}}, div[0]};
  assign period_end = cnt_q == div - DIV_W'(1);
  assign cnt_d      = (load || period_end) ? '0 : cnt_q + DIV_W'(1);
  assign phase_hi   = cnt_d < half;
  assign cnt        = cnt_q;
  always_ff @(posedge clk_in) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free runtime-reconfigurable clock divider; ports clk_in/rst/enable/cfg_valid/cfg_div in, cfg_ready/cfg_err/clk_out/busy out, tick out only with CLK_DIV_CTRL_TICK_EN
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 4
) (
  input  logic             clk_in,
`ifdef CLK_DIV_CTRL_TICK_EN
  output logic             tick,
`endif
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             busy
);
  state_e           state_q, state_d;
  logic [DIV_W-1:0] active_q, active_d, pending_q, pending_d, cnt_unused;
  logic             ready_q, err_q, clk_q, fire, err_d, period_end, phase_hi;
  clk_div_counter #(.DIV_W(DIV_W)) u_cnt (
    .clk_in    (clk_in),
    .rst       (rst),
    .load      (state_q == IDLE),
    .div       (active_q),
    .cnt       (cnt_unused),
    .period_end(period_end),
    .phase_hi  (phase_hi)
  );
  assign fire      = cfg_valid && ready_q && (cfg_div >= DIV_W'(MIN_DIV));
  assign err_d     = cfg_valid && ready_q && (cfg_div < DIV_W'(MIN_DIV));
  assign busy      = state_q != IDLE;
  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign clk_out   = clk_q;
`ifdef CLK_DIV_CTRL_TICK_EN
  assign tick      = busy && period_end;
`endif
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (state_q == IDLE) begin
      active_d = fire ? cfg_div : active_q;
      state_d  = enable ? RUN : IDLE;
    end else if (state_q == RUN) begin
      if (fire) begin
        pending_d = cfg_div;
        state_d   = SWITCH;
      end else if (period_end && !enable) begin
        state_d = IDLE;
      end
    end else if (period_end) begin
      active_d = pending_q;
      state_d  = enable ? RUN : IDLE;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      active_q  <= DIV_W'(DIV_RESET);
      pending_q <= DIV_W'(DIV_RESET);
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ready_q   <= state_d != SWITCH;
      err_q     <= err_d;
      clk_q     <= (state_d != IDLE) && phase_hi;
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed and random checks of clk_div_ctrl against a period/phase reference model
module tb_clk_div_ctrl;
  localparam int DIV_W = 8;
  localparam int DIV_RESET = 4;
  logic clk_in = 1'b0, rst = 1'b0, enable = 1'b0, cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic cfg_ready, cfg_err, clk_out, busy;
`ifdef CLK_DIV_CTRL_TICK_EN
  logic tick;
`endif
  int errors = 0, checks = 0;
  bit m_on, m_rdy, m_err;
  int m_pos, m_n, m_pend;
  logic [7:0] pat;
  clk_div_ctrl #(.DIV_W(DIV_W), .DIV_RESET(DIV_RESET)) dut (
    .clk_in   (clk_in),
`ifdef CLK_DIV_CTRL_TICK_EN
    .tick     (tick),
`endif
    .rst      (rst),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .busy     (busy)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit e, input bit v, input int d);
    bit acc, fire, fin;
    rst = r;
    enable = e;
    cfg_valid = v;
    cfg_div = DIV_W'(d);
    @(posedge clk_in);
    if (r) begin
      m_on = 0; m_pos = 0; m_n = DIV_RESET; m_pend = 0; m_rdy = 0; m_err = 0;
    end else begin
      acc = v && m_rdy;
      fire = acc && d >= 2;
      m_err = acc && d < 2;
      fin = m_on && m_pos == m_n - 1;
      if (!m_on) begin
        if (fire) m_n = d;
        m_on = e;
        m_pos = 0;
      end else if (m_pend != 0) begin
        if (fin) begin
          m_n = m_pend; m_pend = 0; m_on = e; m_pos = 0;
        end else m_pos++;
      end else begin
        if (fire) m_pend = d;
        if (fin) begin
          m_pos = 0;
          if (!e && m_pend == 0) m_on = 0;
        end else m_pos++;
      end
      m_rdy = m_pend == 0;
    end
    #1;
    chk("clk_out", clk_out, m_on && m_pos < (m_n + 1) / 2);
    chk("busy", busy, m_on);
    chk("cfg_ready", cfg_ready, m_rdy);
    chk("cfg_err", cfg_err, m_err);
`ifdef CLK_DIV_CTRL_TICK_EN
    chk("tick", tick, m_on && m_pos == m_n - 1);
`endif
  endtask
  task automatic run_to_pos(input int p, input bit e);
    for (int i = 0; i < 20 && m_pos != p; i++) step(0, e, 0, 0);
  endtask
  initial begin
    step(1, 0, 0, 0);
    step(1, 1, 1, 7);
    chk("reset_ready", cfg_ready, 0);
    chk("reset_clk", clk_out, 0);
    step(0, 0, 0, 0);
    chk("ready_after_release", cfg_ready, 1);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      pat = {pat[6:0], clk_out};
    end
    chk("div4_pattern", pat, 8'b1100_1100);
    run_to_pos(1, 1);
    step(0, 1, 1, 6);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
    run_to_pos(0, 1);
    step(0, 1, 1, 1);
    step(0, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 5);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0);
    run_to_pos(1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("idle_after_drop", busy, 0);
    step(0, 0, 1, 4);
    step(0, 1, 0, 0);
    run_to_pos(1, 1);
    step(1, 1, 0, 0);
    chk("rst_mid_clk", clk_out, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 3);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0);
    run_to_pos(0, 1);
    step(0, 1, 1, 7);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 2);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) == 0, $urandom_range(9) != 0, $urandom_range(3) == 0, $urandom_range(9));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
